// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer: arbitrates host/refresh requests and emits timed SDRAM command strobes.
// Define REFRESH_PREEMPT_EN to let ref_req close an open page and refresh without returning to IDLE.
module sdram_cmd_sequencer #(
  parameter int burst_size = 4,
  parameter int cas_size   = 3,
  parameter int trcd       = 3,
  parameter int trp        = 3,
  parameter int trfc       = 8,
  parameter int twr        = 2
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  output logic                  req_ack,
  input  logic                  ref_req,
  output logic                  ref_ack,
  input  logic                  page_mod,
  input  logic                  page_term,
  input  logic [burst_size-1:0] bur_len,
  input  logic [cas_size-1:0]   cas_lat,
  output logic                  do_active,
  output logic                  do_reada,
  output logic                  do_writea,
  output logic                  do_writea1,
  output logic                  do_preacharge,
  output logic                  do_refresh,
  output logic                  busy
);
  typedef enum logic [3:0] {IDLE, ACT, RCD, RW, BURST, PAGE, PRE, RP, REF, RFC} state_t;
  localparam logic [7:0] LD_RCD = 8'(trcd - 2);
  localparam logic [7:0] LD_RP  = 8'(trp - 1);
  localparam logic [7:0] LD_PRE = 8'(trp - 2);
  localparam logic [7:0] LD_RFC = 8'(trfc - 2);
  localparam logic [7:0] TWR    = 8'(twr);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, bl_q, cl_q, bl_in, cl_in, bl_z;
  logic pm_q, wr_q, pre_ref, pre_ref_n, term;
  assign bl_z  = 8'(bur_len);
  assign bl_in = (bl_z == 8'd1 || bl_z == 8'd2 || bl_z == 8'd4 || bl_z == 8'd8) ? bl_z : 8'd1;
  assign cl_in = (cas_lat == cas_size'(2)) ? 8'd2 : 8'd3;
`ifdef REFRESH_PREEMPT_EN
  assign term = page_term | ref_req;
`else
  assign term = page_term;
`endif
  assign busy    = state != IDLE;
  assign req_ack = do_active;
  assign ref_ack = do_refresh;
  // Counter loads hold (cycles - 1) so a state exits on the cycle cnt is 0.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt - 8'd1;
    pre_ref_n = pre_ref;
    case (state)
      IDLE:  state_n = ref_req ? REF : (req_read | req_write) ? ACT : IDLE;
      ACT: begin
        state_n = RCD;
        cnt_n   = LD_RCD;
      end
      RCD:   state_n = (cnt == 8'd0) ? RW : RCD;
      RW: begin
        state_n = pm_q ? PAGE : BURST;
        cnt_n   = (wr_q ? bl_q + TWR : bl_q + cl_q) - 8'd2;
      end
      BURST: begin
        state_n = (cnt == 8'd0) ? RP : BURST;
        cnt_n   = (cnt == 8'd0) ? LD_RP : cnt - 8'd1;
      end
      PAGE: begin
        state_n = term ? PRE : PAGE;
`ifdef REFRESH_PREEMPT_EN
        pre_ref_n = ref_req;
`endif
      end
      PRE: begin
        state_n = (trp == 1) ? (pre_ref ? REF : IDLE) : RP;
        cnt_n   = LD_PRE;
      end
      RP:    state_n = (cnt != 8'd0) ? RP : pre_ref ? REF : IDLE;
      REF: begin
        state_n   = (trfc == 1) ? IDLE : RFC;
        cnt_n     = LD_RFC;
        pre_ref_n = 1'b0;
      end
      RFC:   state_n = (cnt == 8'd0) ? IDLE : RFC;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pre_ref       <= 1'b0;
      bl_q          <= 8'd1;
      cl_q          <= 8'd3;
      pm_q          <= 1'b0;
      wr_q          <= 1'b0;
      do_active     <= 1'b0;
      do_reada      <= 1'b0;
      do_writea     <= 1'b0;
      do_writea1    <= 1'b0;
      do_preacharge <= 1'b0;
      do_refresh    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pre_ref       <= pre_ref_n;
      do_active     <= state_n == ACT;
      do_reada      <= state_n == RW && !wr_q;
      do_writea     <= state_n == RW && wr_q;
      do_writea1    <= do_writea;
      do_preacharge <= state_n == PRE;
      do_refresh    <= state_n == REF;
      if (state == IDLE && state_n == ACT) begin
        bl_q <= bl_in;
        cl_q <= cl_in;
        pm_q <= page_mod;
        wr_q <= !req_read;
      end
    end
  end
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb_sdram_cmd_sequencer: directed checks of command spacing, priority, page mode and reset.
module tb_sdram_cmd_sequencer;
  logic clk0 = 0, reset = 1;
  logic req_read = 0, req_write = 0, ref_req = 0, page_mod = 0, page_term = 0;
  logic [3:0] bur_len = 4;
  logic [2:0] cas_lat = 2;
  logic req_ack, ref_ack, do_active, do_reada, do_writea, do_writea1, do_preacharge, do_refresh, busy;
  int checks = 0, errors = 0, cyc = 0, viol = 0, n_pre = 0, n_ref = 0;
  int t_act, t_rd, t_wr, t_wr1, t_pre, t_ref, t_idle, t1, t2, nref0;
  logic [4:0] prev = '0;
  logic busy_prev = 0;
  sdram_cmd_sequencer dut (
    .clk0(clk0), .reset(reset), .req_read(req_read), .req_write(req_write), .req_ack(req_ack),
    .ref_req(ref_req), .ref_ack(ref_ack), .page_mod(page_mod), .page_term(page_term),
    .bur_len(bur_len), .cas_lat(cas_lat), .do_active(do_active), .do_reada(do_reada),
    .do_writea(do_writea), .do_writea1(do_writea1), .do_preacharge(do_preacharge),
    .do_refresh(do_refresh), .busy(busy)
  );
  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;
  // Strobe timestamps, exclusivity, width and ack coincidence, sampled mid-cycle.
  always @(negedge clk0) begin
    logic [4:0] s;
    s = {do_active, do_reada, do_writea, do_preacharge, do_refresh};
    if ($countones(s) > 1 || (s & prev) != 0 || req_ack != do_active || ref_ack != do_refresh) viol++;
    prev = s;
    if (do_active) t_act = cyc;
    if (do_reada) t_rd = cyc;
    if (do_writea) t_wr = cyc;
    if (do_writea1) t_wr1 = cyc;
    if (do_preacharge) begin t_pre = cyc; n_pre++; end
    if (do_refresh) begin t_ref = cyc; n_ref++; end
    if (busy_prev && !busy) t_idle = cyc;
    busy_prev = busy;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // which: 0 = req_ack, 1 = ref_ack, 2 = busy low; returns at posedge+1
  task automatic wait_for(input int which, input string tag);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk0);
      #1;
      if ((which == 0 && req_ack) || (which == 1 && ref_ack) || (which == 2 && !busy)) return;
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask
  function automatic logic [8:0] outs();
    return {do_active, do_reada, do_writea, do_writea1, do_preacharge, do_refresh, req_ack, ref_ack, busy};
  endfunction
  task automatic settle();
    wait_for(2, "idle");
    repeat (2) @(posedge clk0);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk0);
    #1;
    chk("reset", outs(), 0);
    reset = 0;
    // read, with a reset pulsed mid-RCD first
    req_read = 1;
    @(posedge clk0);
    #1;
    chk("act_lat", {req_ack, do_active}, 2'b11);
    req_read = 0;
    repeat (2) @(posedge clk0);
    #1;
    reset = 1;
    #1;
    chk("rst_mid", outs(), 0);
    @(posedge clk0);
    #1;
    chk("rst_hold", outs(), 0);
    reset = 0;
    req_read = 1;
    @(posedge clk0);
    #1;
    chk("act_after_rst", do_active, 1);
    req_read = 0;
    settle();
    chk("rd_rcd", t_rd - t_act, 3);
    chk("rd_busy", t_idle - t_rd, 9);
    chk("rd_nopre", n_pre, 0);
    // non-page write, burst 8
    bur_len = 8;
    req_write = 1;
    wait_for(0, "wr_ack");
    req_write = 0;
    settle();
    chk("wr_rcd", t_wr - t_act, 3);
    chk("wr1_delay", t_wr1 - t_wr, 1);
    chk("wr_busy", t_idle - t_wr, 13);
    // all requests at once: refresh, then read, then write
    bur_len = 4;
    {req_read, req_write, ref_req} = 3'b111;
    wait_for(1, "c_ref");
    ref_req = 0;
    wait_for(0, "c_ack1");
    t1 = cyc;
    req_read = 0;
    wait_for(0, "c_ack2");
    t2 = cyc;
    req_write = 0;
    settle();
    chk("c_ref_act", t1 - t_ref, 9);
    chk("c_rd_first", t_rd - t1, 3);
    chk("c_wr_second", t_wr - t2, 3);
    chk("c_b2b", t2 - t1, 13);
    // page-mode write closed by page_term
    page_mod = 1;
    req_write = 1;
    wait_for(0, "pg_ack");
    req_write = 0;
    repeat (20) @(posedge clk0);
    #1;
    chk("pg_hold", busy, 1);
    page_term = 1;
    @(posedge clk0);
    #1;
    chk("pg_pre", do_preacharge, 1);
    page_term = 0;
    settle();
    chk("pg_idle", t_idle - t_pre, 3);
    chk("pg_wr1", t_wr1 - t_wr, 1);
    // refresh request during an open page
    req_read = 1;
    wait_for(0, "pe_ack");
    req_read = 0;
    repeat (5) @(posedge clk0);
    #1;
    nref0 = n_ref;
    ref_req = 1;
`ifdef REFRESH_PREEMPT_EN
    wait_for(1, "pe_ref");
    ref_req = 0;
    chk("pe_ref_gap", cyc - t_pre, 3);
`else
    repeat (10) @(posedge clk0);
    #1;
    chk("pe_noref", n_ref - nref0, 0);
    chk("pe_open", busy, 1);
    page_term = 1;
    @(posedge clk0);
    #1;
    chk("pe_pre", do_preacharge, 1);
    page_term = 0;
    wait_for(1, "pe_ref");
    ref_req = 0;
    chk("pe_late_ref", cyc - t_pre, 4);
`endif
    settle();
    page_term = 1;
    repeat (3) @(posedge clk0);
    #1;
    chk("pt_idle", busy, 0);
    page_term = 0;
    // illegal burst/CAS values, changed after ACT to confirm capture
    page_mod = 0;
    bur_len = 3;
    cas_lat = 5;
    req_read = 1;
    wait_for(0, "odd_ack");
    req_read = 0;
    bur_len = 8;
    cas_lat = 2;
    settle();
    chk("odd_busy", t_idle - t_rd, 7);
    chk("strobe_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_sequencer.md
# sdram_cmd_sequencer

Upstream command sequencer of the SDRAM controller. Arbitrates host read/write requests against refresh requests, enforces tRCD/tRP/tRFC/tWR and burst/CAS occupancy, and emits the single-cycle command strobes (do_active, do_reada, do_writea, do_writea1, do_preacharge, do_refresh). The output-enable generator and data path consume these strobes directly.

## Interface
Parameters:
- burst_size, 4: width of bur_len.
- cas_size, 3: width of cas_lat.
- trcd, 3: do_active to do_reada/do_writea spacing in cycles (≥2).
- trp, 3: precharge to next command in cycles (≥1).
- trfc, 8: do_refresh to next command in cycles (≥1).
- twr, 2: write recovery after last write beat in cycles (≥1).

Ports (reset is asynchronous, active-high; clock is clk0):
- clk0  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_read  in  1  host read request, level, held until req_ack.
- req_write  in  1  host write request, level, held until req_ack.
- req_ack  out  1  one-cycle pulse coincident with do_active.
- ref_req  in  1  refresh request, level, held until ref_ack.
- ref_ack  out  1  one-cycle pulse coincident with do_refresh.
- page_mod  in  1  1 = page mode (no auto-precharge), quasi-static.
- page_term  in  1  terminates an open page-mode access.
- bur_len  in  burst_size  burst length: 1, 2, 4 or 8.
- cas_lat  in  cas_size  CAS latency: 2 or 3.
- do_active, do_reada, do_writea, do_writea1, do_preacharge, do_refresh  out  1 each  registered one-cycle command strobes.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACT, RCD, RW, BURST, PAGE, PRE, RP, REF, RFC.
- IDLE priority is ref_req > req_read > req_write. A request already sampled is acted on even if later deasserted.
- Read/write path: IDLE→ACT (do_active, req_ack)→RCD (trcd−1 cycles)→RW (do_reada or do_writea).
  - page_mod=0: RW→BURST. BURST length is cas_lat+bur_len (read) or bur_len+twr (write). Then RP (trp cycles)→IDLE. No explicit precharge (auto-precharge).
  - page_mod=1: RW→PAGE. PAGE holds until page_term=1, then PRE (do_preacharge)→RP (trp−1 cycles)→IDLE.
- Refresh path: IDLE→REF (do_refresh, ref_ack)→RFC (trfc−1 cycles)→IDLE.
- do_writea1 is do_writea delayed by exactly one cycle, in both modes.
- Width/value rules: bur_len outside {1,2,4,8} is counted as 1. cas_lat other than 2 is counted as 3. The single down-counter is 8 bits wide, loaded on state entry, and the state exits when the count reaches 0.
- bur_len, cas_lat and page_mod are captured at ACT and held for the whole access.
- Requests arriving while busy=1 wait. There is no queueing beyond the held request level.
- Reset mid-operation: all strobes, req_ack, ref_ack and busy go to 0 immediately, and the state returns to IDLE. Pulses are not stretched or replayed.

## Timing
- Reset value of every output is 0.
- Latency from a request sampled in IDLE at edge N: command strobe and ack are high in the cycle following edge N.
- Strobe spacing:
  - do_reada/do_writea follows do_active by exactly trcd cycles.
  - Non-page read: busy drops cas_lat+bur_len+trp cycles after do_reada.
  - Non-page write: busy drops bur_len+twr+trp cycles after do_writea.
- Page mode: page_term sampled high at edge M gives do_preacharge in cycle M+1. busy drops trp cycles after do_preacharge.
- page_term asserted outside PAGE is ignored.
- Refresh: busy drops trfc cycles after do_refresh.
- A new command may issue in the cycle busy first reads 0.
- Every strobe is exactly one cycle wide. At most one of do_active/do_reada/do_writea/do_preacharge/do_refresh is high per cycle.

## Configuration
- REFRESH_PREEMPT_EN defined: in PAGE, ref_req=1 is treated as page_term. The sequencer goes to PRE, issues do_preacharge, then enters REF directly after RP, without passing through IDLE.
- REFRESH_PREEMPT_EN undefined: ref_req is ignored in PAGE. The page stays open until page_term, and the refresh is served from IDLE afterwards.

## Test plan
- Reset mid-RCD (reset pulsed 2 cycles after do_active) -> all outputs 0 during reset. Next req_read gives do_active one cycle after release+sample.
- trcd=3, page_mod=0, bur_len=4, cas_lat=2, req_read -> do_reada 3 cycles after do_active. busy low 2+4+3=9 cycles after do_reada. No do_preacharge.
- page_mod=0, bur_len=8, req_write -> do_writea1 exactly 1 cycle after do_writea. busy low 8+2+3=13 cycles after do_writea.
- req_read, req_write and ref_req all high in IDLE -> do_refresh first, busy 8 cycles, then do_active with req_read served before req_write.
- page_mod=1, req_write, page_term high 20 cycles later -> do_preacharge next cycle, IDLE 3 cycles later. Repeat with ref_req during PAGE: with REFRESH_PREEMPT_EN, do_preacharge then do_refresh 3 cycles later. Without it, no action until page_term.
- bur_len=3, cas_lat=5, non-page read -> BURST counted as bur_len=1, cas_lat=3. busy low 1+3+3=7 cycles after do_reada.
